// File: rtl/operand_normalizer.sv
// Serial left-normalizer for the approximate multiplier's operand pair: emits MW-bit mantissas,
// per-operand shift counts and their sum. Define NORM_ROUND_EN for round-half-up mantissas.

module operand_normalizer_lane #(
  parameter int WIDTH = 16,
  parameter int MW    = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] opnd,
  output logic             done,
  output logic [MW-1:0]    mant,
  output logic [CW-1:0]    sh
);

  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;

  assign done = r[WIDTH-1] | (cnt == CW'(WIDTH));
  assign sh   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      cnt <= '0;
    end else if (load) begin
      r   <= opnd;
      cnt <= '0;
    end else if (step && !done) begin
      r   <= {r[WIDTH-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

`ifdef NORM_ROUND_EN
  // Round-half-up on the first dropped bit; an all-ones carry-out saturates.
  logic [MW:0] rnd;
  always_comb begin
    rnd  = {1'b0, r[WIDTH-1 -: MW]} + (MW+1)'(r[WIDTH-MW-1]);
    mant = rnd[MW] ? {MW{1'b1}} : rnd[MW-1:0];
  end
`else
  assign mant = r[WIDTH-1 -: MW];
`endif

endmodule

module operand_normalizer #(
  parameter int WIDTH = 16,
  parameter int MW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW-1:0]    mant_a,
  output logic [MW-1:0]    mant_b,
  output logic [4:0]       sh_a,
  output logic [4:0]       sh_b,
  output logic [5:0]       sh_sum,
  output logic             zero
);

  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nstate;

  logic [NUM_LANES-1:0][WIDTH-1:0] opnd;
  logic [NUM_LANES-1:0][MW-1:0]    mant;
  logic [NUM_LANES-1:0][CW-1:0]    sh;
  logic [NUM_LANES-1:0]            done;
  logic                            load, step, capture, zero_q;

  assign opnd    = {b_in, a_in};
  assign load    = (state == IDLE) && in_valid;
  assign step    = (state == SHIFT);
  assign capture = step && (&done);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      operand_normalizer_lane #(.WIDTH(WIDTH), .MW(MW), .CW(CW)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .opnd (opnd[g]),
        .done (done[g]),
        .mant (mant[g]),
        .sh   (sh[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid)  nstate = SHIFT;
      SHIFT:   if (&done)     nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result registers only move on capture, so they stay frozen through backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      mant_a <= '0;
      mant_b <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_sum <= '0;
      zero   <= 1'b0;
    end else begin
      if (load) zero_q <= (a_in == '0) || (b_in == '0);
      if (capture) begin
        mant_a <= mant[0];
        mant_b <= mant[1];
        sh_a   <= 5'(sh[0]);
        sh_b   <= 5'(sh[1]);
        sh_sum <= 6'(sh[0]) + 6'(sh[1]);
        zero   <= zero_q;
      end
    end
  end

endmodule

// File: doc/operand_normalizer.md
Name: operand_normalizer

Overview:
- Upstream stage of the approximate multiplier.
- Takes a pair of 16-bit operands and left-normalizes each one serially, one bit per clock, until its MSB is 1.
- Delivers the top 8 bits of each normalized operand (the mantissas that feed the 8x8 multiplier) and the per-operand shift counts.
- Also delivers their sum, which the downstream product shifter uses to re-align the product.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand width; shift counters are $clog2(WIDTH)+1 bits (5 at default).
- MW, 8, mantissa width taken from the top of each normalized operand.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block idle and able to accept.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- mant_a  output  MW  normalized A, top MW bits.
- mant_b  output  MW  normalized B, top MW bits.
- sh_a  output  5  left shifts applied to A (0..16).
- sh_b  output  5  left shifts applied to B (0..16).
- sh_sum  output  6  sh_a + sh_b (0..32), zero-extended, no overflow possible.
- zero  output  1  a_in or b_in was 0 at acceptance.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; out_valid=0.
  - mant_a, mant_b, sh_a, sh_b, sh_sum = 0; zero=0.
  - Internal A/B shift registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: load a_in and b_in into the shift registers, clear both counters, latch zero=(a_in==0)|(b_in==0), go to SHIFT.
- SHIFT:
  - in_ready=0.
  - An operand is done when its register MSB=1 or its counter=WIDTH.
  - Each cycle, every operand that is not done shifts left 1 with 0 fill and increments its counter. Done operands hold.
  - When both operands are done at the start of a cycle, there is no shift. Capture outputs, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; all outputs stable while out_ready=0.
  - On out_ready, clear out_valid and go to IDLE. in_ready returns to 1 in the following cycle; there is no same-cycle accept.
- Latency: out_valid rises max(lzA, lzB)+1 edges after the acceptance edge, where lz is the leading-zero count, capped at 16.
  - Minimum latency is 1; a zero operand gives 17.
- Mantissa: mant_x = register[WIDTH-1 : WIDTH-MW] after normalization. A zero operand gives mant=0 and sh=16.
- Operands with fewer than MW significant bits still normalize fully; the low mantissa bits are zero-filled.
- in_valid outside IDLE is ignored and the operands are not captured.
- out_ready outside DONE is ignored.
- Reset mid-SHIFT or mid-DONE aborts the pending result with no output.

Optional Feature:
- Macro: NORM_ROUND_EN.
- Defined:
  - Each mantissa is rounded to nearest using bit WIDTH-MW-1 of the normalized register (round-half-up).
  - On all-ones overflow the mantissa saturates to 2^MW-1; the shift counts are unchanged.
  - Rounding adds no cycle of latency; it is computed in the capture cycle.
- Undefined: plain truncation.

Test Plan:
- A=0x8000, B=0xFFFF -> out_valid 1 edge after accept; mant_a=0x80, mant_b=0xFF, sh_a=0, sh_b=0, sh_sum=0, zero=0.
- A=0x0001, B=0x0300 -> latency 16; mant_a=0x80, sh_a=15; mant_b=0xC0, sh_b=6; sh_sum=21.
- A=0x0000, B=0x1234 -> latency 17; mant_a=0x00, sh_a=16, zero=1; mant_b=0x91, sh_b=3; sh_sum=19.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new data.
  - All outputs stay stable and in_ready=0.
  - The new data is not taken.
  - After out_ready=1, in_ready=1 on the next cycle.
- Assert rst mid-SHIFT with A=0x0001 at the 5th shift cycle -> all outputs 0 and in_ready=1 immediately; no out_valid follows.
- NORM_ROUND_EN:
  - A=0x0181 -> mant_a=0xC1 (0xC0 when undefined).
  - A=0x01FF -> mant_a=0xFF, saturated; sh_a=7 in both cases.
